// File: rtl/bitfusion_pkg.sv
// Shared encodings for the BitFusion input path: weight bit-width codes,
// sequencer state encoding and the phase-count helper.
package bitfusion_pkg;

  localparam logic [1:0] BW_8 = 2'b00;
  localparam logic [1:0] BW_4 = 2'b01;
  localparam logic [1:0] BW_2 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // Index of the last phase for a weight width; codes 10 and 11 both mean 2b.
  function automatic logic [1:0] phases_for(input logic [1:0] bw);
    logic [1:0] last_idx;
    case (bw)
      BW_8:    last_idx = 2'd0;
      BW_4:    last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
    return last_idx;
  endfunction

endpackage

// File: rtl/input_mux_sequencer.sv
// Streams input-buffer words into the input MUX register, stepping its phase
// select once per issued cycle and flagging valid/last beside sorted_data.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | in_ready high, waiting for the first/next word
// RUN   | word held, phases issued while not stalled
// DONE  | tile finished; done pulses next cycle
module input_mux_sequencer
  import bitfusion_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       weight_bitwidth,
  input  logic [CNT_W-1:0] num_words,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  input  logic             stall,
  output logic [1:0]       mux_state,
  output logic [31:0]      mux_buffer,
  output logic [1:0]       mux_bitwidth,
  output logic             sorted_valid,
  output logic             sorted_last,
  output logic             busy,
  output logic             done
);

  seq_state_t       state;
  seq_state_t       state_next;
  logic [CNT_W-1:0] word_cnt;
  logic             issue;
  logic             accept;
  logic             last_phase;
  logic             more_words;

  // word_cnt counts words still owed including the one being held.
  assign last_phase = (mux_state == phases_for(mux_bitwidth));
  assign more_words = (word_cnt > CNT_W'(1));
  assign accept     = in_ready & in_valid;
  assign busy       = (state != IDLE) | done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (num_words != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        if (accept) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (issue && last_phase) begin
          if (!more_words) begin
            state_next = DONE;
          end else if (!in_valid) begin
            state_next = LOAD;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    issue    = 1'b0;
    in_ready = 1'b0;
    case (state)
      LOAD: in_ready = !stall;
      RUN: begin
        issue    = !stall;
        in_ready = !stall && last_phase && more_words;
      end
      default: begin
        issue    = 1'b0;
        in_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt     <= '0;
      mux_state    <= 2'd0;
      mux_buffer   <= 32'd0;
      mux_bitwidth <= 2'd0;
      sorted_valid <= 1'b0;
      sorted_last  <= 1'b0;
      done         <= 1'b0;
    end else begin
      sorted_valid <= issue;
      sorted_last  <= issue && last_phase && !more_words;
      done         <= (state == DONE);

      if (state == IDLE && start) begin
        mux_bitwidth <= weight_bitwidth;
        word_cnt     <= num_words;
        mux_state    <= 2'd0;
      end

      if (accept) begin
        mux_buffer <= in_data;
      end

      if (issue) begin
        if (!last_phase) begin
          mux_state <= mux_state + 2'd1;
        end else begin
          mux_state <= 2'd0;
          if (more_words) begin
            word_cnt <= word_cnt - CNT_W'(1);
          end
        end
      end
    end
  end

endmodule
